current_pid: RTL and testbench

//  Closed-loop consumer of the assist target current: compares target_curr against the

---
 rtl/current_pid.sv | 184 ++++++++++++++++++
 tb/tb_current_pid.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/current_pid.sv
// Pipelined PI(D) current loop: target_curr vs avg_curr -> drv_mag, 2-cycle latency.
// Optional derivative path built only when D_TERM_EN is defined.
module current_pid #(
  parameter int INT_DEC_W = 2,
  parameter int D_DEPTH   = 2,
  parameter int D_GAIN    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] target_curr,
  input  logic [11:0] avg_curr,
  input  logic        curr_vld,
  input  logic        not_pedaling,
  output logic [11:0] drv_mag,
  output logic        drv_vld
);

  if (INT_DEC_W < 1 || D_DEPTH < 1 || D_GAIN < -8 || D_GAIN > 7) begin : g_bad_param
    $error("current_pid: parameter out of range");
  end

  // 13b two's complement error clamped to [-512, 511]
  function automatic logic [9:0] clamp_err(input logic [12:0] e);
    logic [9:0] r;
    if (!e[12] && (e[11:9] != 3'b000)) begin
      r = 10'h1FF;
    end else if (e[12] && (e[11:9] != 3'b111)) begin
      r = 10'h200;
    end else begin
      r = e[9:0];
    end
    return r;
  endfunction

  // 19b integrator sum clamped to [0, 131071]
  function automatic logic [16:0] clamp_integ(input logic [18:0] s);
    logic [16:0] r;
    if (s[18]) begin
      r = 17'h00000;
    end else if (s[17]) begin
      r = 17'h1FFFF;
    end else begin
      r = s[16:0];
    end
    return r;
  endfunction

  // 15b signed loop sum saturated to the unsigned 12b drive range
  function automatic logic [11:0] sat_drive(input logic [14:0] s);
    logic [11:0] r;
    if (s[14]) begin
      r = 12'h000;
    end else if (s[13:12] != 2'b00) begin
      r = 12'hFFF;
    end else begin
      r = s[11:0];
    end
    return r;
  endfunction

  logic [12:0]          err_s;
  logic [9:0]           err_sat_r;
  logic                 v1_r;
  logic [13:0]          p_s, i_s, p_r, i_r, d_r;
  logic signed [13:0]   d_s;
  logic [18:0]          integ_sum_s;
  logic [16:0]          integ_upd_s;
  logic [16:0]          integ_r;
  logic [INT_DEC_W-1:0] dec_cnt_r;
  logic                 v2_r;
  logic [14:0]          sum_s;

  assign err_s = {1'b0, target_curr} - {1'b0, avg_curr};

  // Stage 1: error capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sat_r <= 10'h000;
      v1_r      <= 1'b0;
    end else if (not_pedaling) begin
      err_sat_r <= 10'h000;
      v1_r      <= curr_vld;
    end else begin
      v1_r <= curr_vld;
      if (curr_vld) begin
        err_sat_r <= clamp_err(err_s);
      end
    end
  end

  // Stage 2 combinational: P term, decimated saturating integrator, I term
  always_comb begin
    p_s         = {{4{err_sat_r[9]}}, err_sat_r};
    integ_sum_s = {2'b00, integ_r} + {{9{err_sat_r[9]}}, err_sat_r};
    if (dec_cnt_r == '0) begin
      integ_upd_s = clamp_integ(integ_sum_s);
    end else begin
      integ_upd_s = integ_r;
    end
    i_s = {1'b0, integ_upd_s[16:4]};
  end

`ifdef D_TERM_EN
  localparam logic signed [13:0] D_GAIN_14 = 14'(D_GAIN);

  logic [9:0]  hist_r [D_DEPTH];
  logic [10:0] diff_s;
  logic [8:0]  diff_c_s;

  // Derivative difference against the oldest history sample, clamped and scaled
  always_comb begin
    diff_s = {err_sat_r[9], err_sat_r} - {hist_r[D_DEPTH-1][9], hist_r[D_DEPTH-1]};
    if (!diff_s[10] && (diff_s[9:8] != 2'b00)) begin
      diff_c_s = 9'h0FF;
    end else if (diff_s[10] && (diff_s[9:8] != 2'b11)) begin
      diff_c_s = 9'h100;
    end else begin
      diff_c_s = diff_s[8:0];
    end
    d_s = $signed({{5{diff_c_s[8]}}, diff_c_s}) * D_GAIN_14;
  end

  // Error history shift register, hist_r[0] newest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < D_DEPTH; k++) hist_r[k] <= 10'h000;
    end else if (not_pedaling) begin
      for (int k = 0; k < D_DEPTH; k++) hist_r[k] <= 10'h000;
    end else if (v1_r) begin
      hist_r[0] <= err_sat_r;
      for (int k = 1; k < D_DEPTH; k++) hist_r[k] <= hist_r[k-1];
    end
  end
`else
  assign d_s = 14'sd0;
`endif

  // Stage 2 registers: terms, integrator, decimation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_r       <= 14'h0000;
      i_r       <= 14'h0000;
      d_r       <= 14'h0000;
      integ_r   <= 17'h00000;
      dec_cnt_r <= '0;
      v2_r      <= 1'b0;
    end else if (not_pedaling) begin
      p_r       <= 14'h0000;
      i_r       <= 14'h0000;
      d_r       <= 14'h0000;
      integ_r   <= 17'h00000;
      dec_cnt_r <= '0;
      v2_r      <= v1_r;
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        p_r       <= p_s;
        i_r       <= i_s;
        d_r       <= d_s;
        integ_r   <= integ_upd_s;
        dec_cnt_r <= dec_cnt_r + INT_DEC_W'(1);
      end
    end
  end

  assign sum_s = {p_r[13], p_r} + {i_r[13], i_r} + {d_r[13], d_r};

  // Stage 3: saturate sum onto drive output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drv_mag <= 12'h000;
      drv_vld <= 1'b0;
    end else if (not_pedaling) begin
      drv_mag <= 12'h000;
      drv_vld <= v2_r;
    end else begin
      drv_vld <= v2_r;
      if (v2_r) begin
        drv_mag <= sat_drive(sum_s);
      end
    end
  end

endmodule

// File: tb/tb_current_pid.sv
// Directed self-checking bench for current_pid; expectations depend on D_TERM_EN.
module tb_current_pid;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] target_curr;
  logic [11:0] avg_curr;
  logic        curr_vld;
  logic        not_pedaling;
  logic [11:0] drv_mag;
  logic        drv_vld;

  int n_checks = 0;
  int n_errors = 0;

`ifdef D_TERM_EN
  localparam logic [11:0] EXP_S1 = 12'h51B;
  localparam logic [11:0] EXP_S2 = 12'h51B;
`else
  localparam logic [11:0] EXP_S1 = 12'h21E;
  localparam logic [11:0] EXP_S2 = 12'h21E;
`endif
  localparam logic [11:0] EXP_S3 = 12'h21E;
  localparam logic [11:0] EXP_S4 = 12'h21E;
  localparam logic [11:0] EXP_S5 = 12'h23E;

  current_pid dut (
    .clk          (clk),
    .rst          (rst),
    .target_curr  (target_curr),
    .avg_curr     (avg_curr),
    .curr_vld     (curr_vld),
    .not_pedaling (not_pedaling),
    .drv_mag      (drv_mag),
    .drv_vld      (drv_vld)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    curr_vld = 1'b0;
    not_pedaling = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One isolated strobe; checks latency, pulse width and value
  task automatic sample_one(input string tag, input logic [11:0] t, input logic [11:0] a,
                            input logic [11:0] exp);
    @(negedge clk);
    target_curr = t;
    avg_curr    = a;
    curr_vld    = 1'b1;
    @(negedge clk);
    curr_vld = 1'b0;
    check_value({tag, "_vld_k"}, 32'(drv_vld), 32'h0);
    @(negedge clk);
    check_value({tag, "_vld_k1"}, 32'(drv_vld), 32'h0);
    @(negedge clk);
    check_value({tag, "_vld_k2"}, 32'(drv_vld), 32'h1);
    check_value({tag, "_mag"}, 32'(drv_mag), 32'(exp));
    @(negedge clk);
    check_value({tag, "_vld_end"}, 32'(drv_vld), 32'h0);
  endtask

  initial begin
    int late_cnt;
    logic [11:0] seen;
    rst = 1'b1;
    target_curr = 12'h000;
    avg_curr = 12'h000;
    curr_vld = 1'b0;
    not_pedaling = 1'b0;
    repeat (3) @(negedge clk);
    check_value("rst_mag", 32'(drv_mag), 32'h0);
    check_value("rst_vld", 32'(drv_vld), 32'h0);
    rst = 1'b0;

    // Basic loop, including derivative decay and second integrator update
    sample_one("t1_s1", 12'h300, 12'h100, EXP_S1);
    sample_one("t1_s2", 12'h300, 12'h100, EXP_S2);
    sample_one("t1_s3", 12'h300, 12'h100, EXP_S3);
    sample_one("t1_s4", 12'h300, 12'h100, EXP_S4);
    sample_one("t1_s5", 12'h300, 12'h100, EXP_S5);

    // Large negative error: clamped, integrator floor at 0
    do_reset();
    sample_one("t2", 12'h000, 12'hFFF, 12'h000);
    check_value("t2_integ", 32'(dut.integ_r), 32'h0);

    // Integrator saturation under sustained positive error
    @(negedge clk);
    target_curr = 12'hFFF;
    avg_curr = 12'h000;
    curr_vld = 1'b1;
    repeat (1100) @(negedge clk);
    check_value("t3_integ_sat", 32'(dut.integ_r), 32'h1FFFF);
    check_value("t3_mag_sat", 32'(drv_mag), 32'hFFF);
    target_curr = 12'h555;
    avg_curr = 12'h555;
    repeat (8) @(negedge clk);
    curr_vld = 1'b0;
    repeat (3) @(negedge clk);
    check_value("t3_integ_hold", 32'(dut.integ_r), 32'h1FFFF);
    check_value("t3_mag_hold", 32'(drv_mag), 32'hFFF);

    // not_pedaling for 5 cycles, one strobe inside it
    not_pedaling = 1'b1;
    @(negedge clk);
    check_value("t4_mag_zero", 32'(drv_mag), 32'h0);
    check_value("t4_integ_zero", 32'(dut.integ_r), 32'h0);
    target_curr = 12'h300;
    avg_curr = 12'h100;
    curr_vld = 1'b1;
    @(negedge clk);
    curr_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_value("t4_np_vld", 32'(drv_vld), 32'h1);
    check_value("t4_np_mag", 32'(drv_mag), 32'h0);
    @(negedge clk);
    not_pedaling = 1'b0;
    repeat (3) @(negedge clk);
    sample_one("t4_restart", 12'h300, 12'h100, EXP_S1);

    // Reset with two samples in flight
    @(negedge clk);
    target_curr = 12'h300;
    avg_curr = 12'h100;
    curr_vld = 1'b1;
    repeat (2) @(negedge clk);
    curr_vld = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_value("t5_mag_async", 32'(drv_mag), 32'h0);
    check_value("t5_vld_async", 32'(drv_vld), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    late_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (drv_vld) late_cnt++;
    end
    check_value("t5_no_late_vld", 32'(late_cnt), 32'h0);

    // Eight back-to-back strobes
    @(negedge clk);
    target_curr = 12'h200;
    avg_curr = 12'h200;
    curr_vld = 1'b1;
    seen = 12'h000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 7) curr_vld = 1'b0;
      seen[i] = drv_vld;
    end
    check_value("t6_vld_pattern", 32'(seen), 32'h3FC);
    check_value("t6_mag", 32'(drv_mag), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
